// File: rtl/mutex_merge_arb.sv
// mutex_merge_arb
//
// Purpose:
//   Serialises one-cycle drive pulses from CHANNELS upstream controllers onto a
//   single downstream drive/free handshake. Requests are latched in a pending
//   register, so simultaneous requests wait their turn instead of being lost.
//   One owner at a time is selected by fixed-priority or round-robin
//   arbitration.
//
// Handshake (all signals are single-cycle pulses, sampled on the rising edge):
//   i_drive[i] requests channel i. The owner is published on o_data/o_index from
//   the grant edge onwards. o_driveNext pulses once the programmed latency has
//   elapsed. Downstream answers with i_freeNext. The owner then receives
//   o_free[i] for exactly one cycle, and the block returns to IDLE.
//
// Parameters:
//   CHANNELS      number of upstream channels (2..64)
//   ARB_MODE      0 = fixed priority (lowest index wins), 1 = round-robin
//   DRIVE_LATENCY cycles from grant to the o_driveNext pulse (1..15)
//   IDX_W         width of o_index
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   i_drive      per-channel request pulses
//   o_free       per-channel release pulse to the owner
//   o_driveNext  drive pulse to downstream
//   i_freeNext   completion pulse from downstream
//   o_data       one-hot owner vector (0 when no owner)
//   o_index      encoded owner (0 when no owner)
//   o_busy       high in any state other than IDLE
//   o_overlap    sticky protocol error flag
//   o_state      debug view of the FSM state (0 IDLE, 1 DELAY, 2 WAIT_FREE, 3 RELEASE)
//
// Build option:
//   MUTEX_MERGE_OVERLAP_CHECK_EN - when defined, o_overlap latches on a request
//   for a channel that is already pending, or on i_freeNext outside WAIT_FREE.
//   When undefined, o_overlap is tied low and no detection logic exists.

module mutex_merge_arb #(
    parameter int CHANNELS      = 32,
    parameter int ARB_MODE      = 1,
    parameter int DRIVE_LATENCY = 2,
    parameter int IDX_W         = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i_drive,
    output logic [CHANNELS-1:0] o_free,
    output logic                o_driveNext,
    input  logic                i_freeNext,
    output logic [CHANNELS-1:0] o_data,
    output logic [IDX_W-1:0]    o_index,
    output logic                o_busy,
    output logic                o_overlap,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DELAY     = 2'd1,
        WAIT_FREE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    state_t              state, state_next;
    logic [CHANNELS-1:0] pending, pending_next;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]    owner, owner_next;
    logic [3:0]          counter, counter_next;
    logic                release_now;
    logic [CHANNELS-1:0] owner_vec;

    // Arbiter: scan CHANNELS positions starting at 'base', wrapping to 0.
    // Fixed priority always starts at 0; round-robin starts just past the
    // last owner. rr_ptr resets to CHANNELS-1 so the first scan starts at 0.
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_found;
    int                  base;
    int                  scan;
    logic [IDX_W-1:0]    scan_idx;

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        scan        = 0;
        scan_idx    = '0;
        base        = (ARB_MODE == 1) ? int'(rr_ptr) + 1 : 0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan = base + k;
            if (scan >= CHANNELS) begin
                scan = scan - CHANNELS;
            end
            scan_idx = IDX_W'(scan);
            if (!grant_found && pending[scan_idx]) begin
                grant_idx   = scan_idx;
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
            rr_ptr  <= IDX_W'(CHANNELS - 1);
            owner   <= '0;
            counter <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            rr_ptr  <= rr_ptr_next;
            owner   <= owner_next;
            counter <= counter_next;
        end
    end

    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        owner_next   = owner;
        counter_next = counter;
        release_now  = 1'b0;
        owner_vec    = ONE << owner;

        o_free       = '0;
        o_driveNext  = 1'b0;
        o_data       = '0;
        o_index      = '0;
        o_busy       = (state != IDLE);
        o_state      = state;

        case (state)
            IDLE: begin
                if (grant_found) begin
                    owner_next   = grant_idx;
                    rr_ptr_next  = grant_idx;
                    counter_next = 4'(DRIVE_LATENCY - 1);
                    state_next   = DELAY;
                end
            end
            DELAY: begin
                o_data  = owner_vec;
                o_index = owner;
                if (counter == 4'd0) begin
                    o_driveNext = 1'b1;
                    state_next  = WAIT_FREE;
                end else begin
                    counter_next = counter - 4'd1;
                end
            end
            WAIT_FREE: begin
                o_data  = owner_vec;
                o_index = owner;
                if (i_freeNext) begin
                    release_now = 1'b1;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                o_free     = owner_vec;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A pulse on an already-pending channel is absorbed by the OR. The
        // owner's bit clears on RELEASE entry, so a pulse during the o_free
        // cycle re-arms the channel as a fresh request.
        pending_next = (pending | i_drive) & ~(release_now ? owner_vec : '0);
    end

`ifdef MUTEX_MERGE_OVERLAP_CHECK_EN
    logic overlap_q;
    logic overlap_event;

    assign overlap_event = (|(i_drive & pending)) || (i_freeNext && (state != WAIT_FREE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overlap_q <= 1'b0;
        end else if (overlap_event) begin
            overlap_q <= 1'b1;
        end
    end

    assign o_overlap = overlap_q;
`else
    assign o_overlap = 1'b0;
`endif

endmodule

// File: tb/tb_mutex_merge_arb.sv
// tb_mutex_merge_arb
//
// Two instances share clock and reset:
//   dut_a: CHANNELS=32, round-robin, DRIVE_LATENCY=2
//   dut_b: CHANNELS=32, fixed priority, DRIVE_LATENCY=1
// Expected grant indices are queued when requests are driven. A monitor pops
// them as owners appear and checks the one-hot vector, owner stability and the
// o_free target. A responder answers o_driveNext with i_freeNext one cycle
// later unless a step takes manual control of i_freeNext.

module tb_mutex_merge_arb;

    localparam int CH = 32;
    localparam int IW = 5;

`ifdef MUTEX_MERGE_OVERLAP_CHECK_EN
    localparam logic OVL_EXP = 1'b1;
`else
    localparam logic OVL_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [CH-1:0] a_drive, a_free, a_data;
    logic          a_drvn, a_freen, a_busy, a_ovl;
    logic [IW-1:0] a_index;
    logic [1:0]    a_state;

    logic [CH-1:0] b_drive, b_free, b_data;
    logic          b_drvn, b_freen, b_busy, b_ovl;
    logic [IW-1:0] b_index;
    logic [1:0]    b_state;

    mutex_merge_arb #(.CHANNELS(CH), .ARB_MODE(1), .DRIVE_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .i_drive(a_drive), .o_free(a_free),
        .o_driveNext(a_drvn), .i_freeNext(a_freen), .o_data(a_data),
        .o_index(a_index), .o_busy(a_busy), .o_overlap(a_ovl), .o_state(a_state)
    );

    mutex_merge_arb #(.CHANNELS(CH), .ARB_MODE(0), .DRIVE_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .i_drive(b_drive), .o_free(b_free),
        .o_driveNext(b_drvn), .i_freeNext(b_freen), .o_data(b_data),
        .o_index(b_index), .o_busy(b_busy), .o_overlap(b_ovl), .o_state(b_state)
    );

    // Responder / manual i_freeNext selection.
    logic auto_a, auto_b, resp_a, resp_b, seen_a, seen_b, man_a, man_b;
    assign a_freen = auto_a ? resp_a : man_a;
    assign b_freen = auto_b ? resp_b : man_b;

    int tests;
    int fails;
    int cyc;

    logic [IW-1:0] exp_a[$];
    logic [IW-1:0] exp_b[$];
    logic [CH-1:0] prev_data[2];
    logic [IW-1:0] cur_idx[2];
    int            free_cnt[2];
    int            last_grant[2];
    int            gap[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] onehot(input logic [IW-1:0] i);
        logic [CH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic mon(input int k, input logic [CH-1:0] data, input logic [IW-1:0] idx,
                       input logic [CH-1:0] free);
        logic [IW-1:0] e;
        int            sz;
        sz = (k == 0) ? exp_a.size() : exp_b.size();
        if (data != '0 && prev_data[k] == '0) begin
            check($sformatf("sb_grant_expected_dut%0d", k), 64'(sz != 0), 64'(1));
            if (sz != 0) begin
                if (k == 0) e = exp_a.pop_front();
                else        e = exp_b.pop_front();
                check($sformatf("sb_grant_index_dut%0d", k), 64'(idx), 64'(e));
                check($sformatf("sb_grant_onehot_dut%0d", k), 64'(data), 64'(onehot(e)));
                cur_idx[k]    = e;
                gap[k]        = cyc - last_grant[k];
                last_grant[k] = cyc;
            end
        end else if (data != '0) begin
            check($sformatf("sb_owner_hold_dut%0d", k), 64'(data), 64'(onehot(cur_idx[k])));
        end
        if (free != '0) begin
            free_cnt[k]++;
            check($sformatf("sb_free_target_dut%0d", k), 64'(free), 64'(onehot(cur_idx[k])));
        end
        prev_data[k] = data;
    endtask

    task automatic pulse_a(input logic [CH-1:0] mask);
        @(negedge clk);
        a_drive = mask;
        @(negedge clk);
        a_drive = '0;
    endtask

    task automatic pulse_b(input logic [CH-1:0] mask);
        @(negedge clk);
        b_drive = mask;
        @(negedge clk);
        b_drive = '0;
    endtask

    task automatic wait_grant(input int k, input logic [IW-1:0] idx, input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (k == 0) seen = (a_data != '0) && (a_index == idx);
            else        seen = (b_data != '0) && (b_index == idx);
        end
        check(tag, 64'(seen), 64'(1));
    endtask

    task automatic wait_idle(input int k, input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (k == 0) done = !a_busy && (exp_a.size() == 0);
            else        done = !b_busy && (exp_b.size() == 0);
        end
        check(tag, 64'(done), 64'(1));
    endtask

    initial begin
        int free_before;

        tests = 0;
        fails = 0;
        cyc = 0;
        rst = 1'b0;
        a_drive = '0;
        b_drive = '0;
        auto_a = 1'b1;
        auto_b = 1'b1;
        resp_a = 1'b0;
        resp_b = 1'b0;
        seen_a = 1'b0;
        seen_b = 1'b0;
        man_a = 1'b0;
        man_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prev_data[k] = '0;
            cur_idx[k] = '0;
            free_cnt[k] = 0;
            last_grant[k] = 0;
            gap[k] = 0;
        end

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                mon(0, a_data, a_index, a_free);
                mon(1, b_data, b_index, b_free);
            end
            forever begin
                @(negedge clk);
                resp_a = seen_a;
                seen_a = a_drvn;
                resp_b = seen_b;
                seen_b = b_drvn;
            end
        join_none

        // ---- Reset state ----
        @(negedge clk);
        check("rst_a_data", 64'(a_data), 64'(0));
        check("rst_a_index", 64'(a_index), 64'(0));
        check("rst_a_free", 64'(a_free), 64'(0));
        check("rst_a_drvn", 64'(a_drvn), 64'(0));
        check("rst_a_busy", 64'(a_busy), 64'(0));
        check("rst_a_ovl", 64'(a_ovl), 64'(0));
        check("rst_a_state", 64'(a_state), 64'(0));
        check("rst_b_data", 64'(b_data), 64'(0));
        check("rst_b_state", 64'(b_state), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---- Single request on channel 5, cycle-exact timing ----
        exp_a.push_back(5'd5);
        @(negedge clk);
        a_drive = onehot(5'd5);
        @(negedge clk);
        a_drive = '0;
        check("t1_not_before_pulse_edge", 64'(a_data), 64'(0));
        @(negedge clk);
        check("t1_grant_data", 64'(a_data), 64'(32'h20));
        check("t1_grant_index", 64'(a_index), 64'(5));
        check("t1_busy", 64'(a_busy), 64'(1));
        check("t1_drvn_not_yet", 64'(a_drvn), 64'(0));
        @(negedge clk);
        check("t1_drvn_pulse", 64'(a_drvn), 64'(1));
        check("t1_data_stable", 64'(a_data), 64'(32'h20));
        @(negedge clk);
        check("t1_drvn_one_cycle", 64'(a_drvn), 64'(0));
        check("t1_no_early_free", 64'(a_free), 64'(0));
        @(negedge clk);
        check("t1_free_pulse", 64'(a_free), 64'(32'h20));
        check("t1_data_cleared", 64'(a_data), 64'(0));
        check("t1_index_cleared", 64'(a_index), 64'(0));
        @(negedge clk);
        check("t1_free_one_cycle", 64'(a_free), 64'(0));
        check("t1_idle", 64'(a_busy), 64'(0));

        // ---- Round-robin: 0,1,4 together; then 0 and 4 while 1 is owner ----
        // Channel 4 is still pending when the pair arrives, so its pulse is
        // absorbed; after 1 the scan starts at 2, reaching 4 before 0.
        exp_a.push_back(5'd0);
        exp_a.push_back(5'd1);
        pulse_a(32'h0000_0013);
        wait_grant(0, 5'd1, "t2_rr_grant1_seen");
        exp_a.push_back(5'd4);
        exp_a.push_back(5'd0);
        pulse_a(onehot(5'd0) | onehot(5'd4));
        check("t2_overlap_flag", 64'(a_ovl), 64'(OVL_EXP));
        wait_grant(0, 5'd4, "t2_rr_grant4_seen");
        check("t2_back_to_back_gap", 64'(gap[0]), 64'(5));
        wait_idle(0, "t2_rr_drained");

        // ---- Fixed priority with latency 1 ----
        exp_b.push_back(5'd6);
        @(negedge clk);
        b_drive = onehot(5'd6);
        @(negedge clk);
        b_drive = '0;
        @(negedge clk);
        check("t3_lat1_grant", 64'(b_data), 64'(onehot(5'd6)));
        check("t3_lat1_drvn_same_cycle", 64'(b_drvn), 64'(1));
        @(negedge clk);
        check("t3_lat1_drvn_one_cycle", 64'(b_drvn), 64'(0));
        wait_idle(1, "t3_lat1_drained");

        exp_b.push_back(5'd0);
        exp_b.push_back(5'd1);
        exp_b.push_back(5'd4);
        pulse_b(32'h0000_0013);
        wait_idle(1, "t3_fp_batch_drained");
        check("t3_fp_back_to_back_gap", 64'(gap[1]), 64'(4));
        exp_b.push_back(5'd0);
        exp_b.push_back(5'd4);
        pulse_b(onehot(5'd0) | onehot(5'd4));
        wait_idle(1, "t3_fp_pair_drained");

        // ---- Reset during WAIT_FREE: owner 3, channels 7 and 9 pending ----
        auto_a = 1'b0;
        man_a  = 1'b0;
        exp_a.push_back(5'd3);
        pulse_a(onehot(5'd3));
        wait_grant(0, 5'd3, "t4_grant3_seen");
        pulse_a(onehot(5'd7) | onehot(5'd9));
        repeat (2) @(negedge clk);
        check("t4_waiting_owner", 64'(a_data), 64'(onehot(5'd3)));
        check("t4_waiting_busy", 64'(a_busy), 64'(1));
        free_before = free_cnt[0];
        rst = 1'b0;
        #1;
        check("t4_async_data", 64'(a_data), 64'(0));
        check("t4_async_index", 64'(a_index), 64'(0));
        check("t4_async_busy", 64'(a_busy), 64'(0));
        check("t4_async_free", 64'(a_free), 64'(0));
        check("t4_async_ovl", 64'(a_ovl), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        auto_a = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_stays_idle", 64'(a_busy), 64'(0));
        check("t4_no_owner", 64'(a_data), 64'(0));
        check("t4_no_free_issued", 64'(free_cnt[0]), 64'(free_before));

        // ---- Wrap: rr_ptr is CHANNELS-1 after reset ----
        exp_a.push_back(5'd31);
        pulse_a(onehot(5'd31));
        wait_grant(0, 5'd31, "t5_wrap_grant31");
        wait_idle(0, "t5_wrap_drained");
        exp_a.push_back(5'd0);
        exp_a.push_back(5'd31);
        pulse_a(onehot(5'd0) | onehot(5'd31));
        wait_idle(0, "t5_wrap_pair_drained");

        // ---- Overlap: second pulse on pending channel 2, stray i_freeNext ----
        free_before = free_cnt[0];
        exp_a.push_back(5'd2);
        pulse_a(onehot(5'd2));
        wait_grant(0, 5'd2, "t6_grant2_seen");
        pulse_a(onehot(5'd2));
        check("t6_overlap_next_cycle", 64'(a_ovl), 64'(OVL_EXP));
        wait_idle(0, "t6_drained");
        repeat (5) @(negedge clk);
        check("t6_single_free", 64'(free_cnt[0] - free_before), 64'(1));
        check("t6_overlap_sticky", 64'(a_ovl), 64'(OVL_EXP));

        @(negedge clk);
        auto_b = 1'b0;
        man_b  = 1'b1;
        @(negedge clk);
        man_b  = 1'b0;
        auto_b = 1'b1;
        check("t6_stray_free_overlap", 64'(b_ovl), 64'(OVL_EXP));
        check("t6_stray_free_ignored", 64'(b_busy), 64'(0));
        repeat (3) @(negedge clk);
        check("t6_stray_overlap_sticky", 64'(b_ovl), 64'(OVL_EXP));

        check("end_queue_a_empty", 64'(exp_a.size()), 64'(0));
        check("end_queue_b_empty", 64'(exp_b.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
